// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults for the multi-port register file.
//   DEFAULT_WIDTH    - data width of one register
//   DEFAULT_DEPTH    - number of registers (power of two, >= 2)
//   DEFAULT_NUM_READ - number of combinational read ports (1..4)
//   reg_data_t       - one register word at the default width
package regfile_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_DEPTH    = 8;
  localparam int DEFAULT_NUM_READ = 2;

  typedef logic [DEFAULT_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy tracking for issue logic.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   write_enable        - writeback strobe; clears busy[write_reg]
//   write_reg           - writeback address
//   reserve_enable      - request to mark reserve_reg busy
//   reserve_reg         - register to reserve
//   busy                - full busy vector (read by the top-level read muxes)
//   reserve_ok          - combinational: reservation accepted this cycle
//   busy_count          - registered count of busy registers, 0..DEPTH
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          write_enable,
  input  logic [AW-1:0] write_reg,
  input  logic          reserve_enable,
  input  logic [AW-1:0] reserve_reg,
  output logic [DEPTH-1:0] busy,
  output logic          reserve_ok,
  output logic [AW:0]   busy_count
);

  localparam logic [AW:0] ONE = 1;

  logic reserve_zero;
  logic write_zero;
  logic write_same;
  logic write_clear;
  logic count_inc;
  logic count_dec;

  assign reserve_zero = (ZERO_REG != 0) && (reserve_reg == '0);
  assign write_zero   = (ZERO_REG != 0) && (write_reg == '0);
  assign write_same   = write_enable && (write_reg == reserve_reg);

  // A busy register can be re-reserved only when its producer writes back
  // in the same cycle (the new reservation takes over).
  assign reserve_ok  = reserve_enable && (!busy[reserve_reg] || write_same) && !reserve_zero;
  assign write_clear = write_enable && !write_zero;

  // The count moves only when the population of busy bits really changes:
  // a write that clears a register which is immediately re-reserved leaves
  // it busy, so that case is not a decrement.
  assign count_inc = reserve_ok && !busy[reserve_reg];
  assign count_dec = write_clear && busy[write_reg] && !(reserve_ok && write_same);

  // NOTE: sequential state uses non-blocking assignments only; the two
  // updates of busy below are ordered so the reserve (written last) wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (write_clear) busy[write_reg]   <= 1'b0;
      if (reserve_ok)  busy[reserve_reg] <= 1'b1;
      if (count_inc && !count_dec)      busy_count <= busy_count + ONE;
      else if (count_dec && !count_inc) busy_count <= busy_count - ONE;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: DEPTH x WIDTH register file with NUM_READ combinational read
// ports, one synchronous write port and an integrated busy scoreboard.
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-to-read
// forwarding (default: reads reflect registered state only).
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   read_reg        - NUM_READ packed read addresses (port p at [p*AW +: AW])
//   read_data       - NUM_READ packed read words (port p at [p*WIDTH +: WIDTH])
//   read_busy       - busy bit of each addressed register
//   write_enable    - writeback strobe
//   write_reg       - writeback address
//   write_data      - writeback data
//   reserve_enable  - request to mark reserve_reg busy
//   reserve_reg     - register to reserve
//   reserve_ok      - combinational: reservation accepted this cycle
//   busy_count      - registered number of busy registers
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int NUM_READ = DEFAULT_NUM_READ,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_READ*AW-1:0] read_reg,
  output logic [NUM_READ*WIDTH-1:0] read_data,
  output logic [NUM_READ-1:0]    read_busy,
  input  logic                   write_enable,
  input  logic [AW-1:0]          write_reg,
  input  logic [WIDTH-1:0]       write_data,
  input  logic                   reserve_enable,
  input  logic [AW-1:0]          reserve_reg,
  output logic                   reserve_ok,
  output logic [AW:0]            busy_count
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             write_accept;

  // Writes to a hardwired zero register are dropped entirely.
  assign write_accept = write_enable && !((ZERO_REG != 0) && (write_reg == '0));

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk            (clk),
    .rst_n          (rst_n),
    .write_enable   (write_enable),
    .write_reg      (write_reg),
    .reserve_enable (reserve_enable),
    .reserve_reg    (reserve_reg),
    .busy           (busy),
    .reserve_ok     (reserve_ok),
    .busy_count     (busy_count)
  );

  // NOTE: the data array is reset on purpose (reads must return zero after
  // reset), so it is built from flops rather than an inferred RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_accept) begin
      regs[write_reg] <= write_data;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_read
    logic [AW-1:0] addr;
    assign addr = read_reg[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    // Forwarded data is fresh, so the port is not busy unless a reserve
    // accepted this same cycle claims the register again.
    logic fwd;
    assign fwd = write_accept && (addr == write_reg);
    assign read_data[p*WIDTH +: WIDTH] = fwd ? write_data : regs[addr];
    assign read_busy[p] = fwd ? (reserve_ok && (reserve_reg == write_reg)) : busy[addr];
`else
    assign read_data[p*WIDTH +: WIDTH] = regs[addr];
    assign read_busy[p] = busy[addr];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp. Two instances share all
// inputs: dut 0 with ZERO_REG=0 and dut 1 with ZERO_REG=1. A driver issues
// one operation per cycle, computes the expected outputs from an array
// model and queues them; a monitor pops one entry per cycle on the falling
// edge and compares every output of both instances.
module tb_regfile_mp;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int NR = 2;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] read_reg = '0;
  logic             we = 1'b0;
  logic [AW-1:0]    wr = '0;
  logic [W-1:0]     wd = '0;
  logic             re = 1'b0;
  logic [AW-1:0]    rr = '0;

  logic [NR*W-1:0]  rdata [2];
  logic [NR-1:0]    rbusy [2];
  logic             rok   [2];
  logic [AW:0]      cnt   [2];

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NUM_READ(NR), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .read_reg(read_reg), .read_data(rdata[0]),
    .read_busy(rbusy[0]), .write_enable(we), .write_reg(wr), .write_data(wd),
    .reserve_enable(re), .reserve_reg(rr), .reserve_ok(rok[0]), .busy_count(cnt[0]));

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NUM_READ(NR), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .read_reg(read_reg), .read_data(rdata[1]),
    .read_busy(rbusy[1]), .write_enable(we), .write_reg(wr), .write_data(wd),
    .reserve_enable(re), .reserve_reg(rr), .reserve_ok(rok[1]), .busy_count(cnt[1]));

  // Reference model: plain arrays of register contents and busy flags.
  logic [W-1:0] mem [2][D];
  bit           bsy [2][D];

  typedef struct {
    int              cyc;
    logic [NR*W-1:0] data [2];
    logic [NR-1:0]   busy [2];
    logic            rok  [2];
    logic [AW:0]     cnt  [2];
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   done  = 0;

  task automatic check(input string name, input int z, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, z, c, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < D; i++) begin
        mem[z][i] = '0;
        bsy[z][i] = 0;
      end
  endfunction

  // Expected outputs for the inputs currently applied, before the edge.
  function automatic exp_t build_exp();
    exp_t e;
    e.cyc = cyc;
    for (int z = 0; z < 2; z++) begin
      bit zr = (z == 1);
      int n = 0;
      e.rok[z] = re && (!bsy[z][rr] || (we && wr == rr)) && !(zr && rr == 0);
      for (int p = 0; p < NR; p++) begin
        int a = int'(read_reg[p*AW +: AW]);
        logic [W-1:0] d = mem[z][a];
        logic b = bsy[z][a];
`ifdef REGFILE_BYPASS_EN
        if (we && a == int'(wr) && !(zr && wr == 0)) begin
          d = wd;
          b = e.rok[z] && (rr == wr);
        end
`endif
        e.data[z][p*W +: W] = d;
        e.busy[z][p] = b;
      end
      for (int i = 0; i < D; i++) n += int'(bsy[z][i]);
      e.cnt[z] = (AW+1)'(n);
    end
    return e;
  endfunction

  // State after the edge: write clears busy, an accepted reserve sets it.
  function automatic void model_update(input exp_t e);
    for (int z = 0; z < 2; z++) begin
      if (we && !(z == 1 && wr == 0)) begin
        mem[z][wr] = wd;
        bsy[z][wr] = 0;
      end
      if (e.rok[z]) bsy[z][rr] = 1;
    end
  endfunction

  task automatic step(input logic w_en, input int w_reg, input int w_dat,
                      input logic r_en, input int r_reg, input int a0, input int a1);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    we = w_en; wr = AW'(w_reg); wd = W'(w_dat);
    re = r_en; rr = AW'(r_reg);
    read_reg = {AW'(a1), AW'(a0)};
    e = build_exp();
    q.push_back(e);
    model_update(e);
    cyc++;
  endtask

  task automatic do_reset(input int a0, input int a1);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    we = 1'b0; re = 1'b0; wr = '0; rr = '0; wd = '0;
    read_reg = {AW'(a1), AW'(a0)};
    model_clear();
    e = build_exp();
    q.push_back(e);
    cyc++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int z = 0; z < 2; z++) begin
          for (int p = 0; p < NR; p++) begin
            check("read_data", z, e.cyc, 32'(rdata[z][p*W +: W]), 32'(e.data[z][p*W +: W]));
            check("read_busy", z, e.cyc, 32'(rbusy[z][p]), 32'(e.busy[z][p]));
          end
          check("reserve_ok", z, e.cyc, 32'(rok[z]), 32'(e.rok[z]));
          check("busy_count", z, e.cyc, 32'(cnt[z]), 32'(e.cnt[z]));
        end
      end
    end
  end

  initial begin : driver
    model_clear();
    do_reset(0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // Reset mid-run after writing R3.
    step(1, 3, 'hA5, 0, 0, 3, 3);
    step(0, 0, 0, 0, 0, 3, 3);
    do_reset(3, 3);
    step(0, 0, 0, 0, 0, 3, 3);
    // Write/read on consecutive edges.
    step(1, 0, 'hA5, 0, 0, 0, 1);
    step(1, 1, 'h5A, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // Reserve twice, then write back.
    step(0, 0, 0, 1, 2, 2, 2);
    step(0, 0, 0, 1, 2, 2, 2);
    step(1, 2, 'h33, 0, 0, 2, 2);
    step(0, 0, 0, 0, 0, 2, 2);
    // Simultaneous write and reserve.
    step(0, 0, 0, 1, 4, 4, 4);
    step(1, 4, 'h11, 1, 4, 4, 4);
    step(1, 4, 'h22, 1, 5, 4, 5);
    step(0, 0, 0, 0, 0, 4, 5);
    // Register 0 write and reserve (dropped on the zero-register instance).
    step(1, 0, 'hFF, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Write while both ports read the same register.
    step(1, 6, 'h7E, 0, 0, 6, 6);
    step(0, 0, 0, 0, 0, 6, 6);
    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset(int'($urandom_range(0, D-1)), int'($urandom_range(0, D-1)));
      end else begin
        int w_r = int'($urandom_range(0, D-1));
        int r_r = ($urandom_range(0, 3) == 0) ? w_r : int'($urandom_range(0, D-1));
        step(logic'($urandom_range(0, 1)), w_r, int'($urandom_range(0, 255)),
             logic'($urandom_range(0, 1)), r_r,
             int'($urandom_range(0, D-1)), int'($urandom_range(0, D-1)));
      end
    end
    done = 1;
  end

  initial begin : finisher
    wait (done);
    repeat (4) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
